chan_mux_rr: RTL and testbench
==============================

CHAN_MUX_RR -- requirements
Module: chan_mux_rr

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of input channels (legal 2..16).
REQ-002 SHALL have parameter W, default 8, meaning data width per channel (legal 1..64).
REQ-003 SHALL have parameter SW, default 2, meaning select/channel-index width (SW = clog2(NCH)).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset sampled on rising clk.
REQ-006 SHALL have port in_data  input  NCH*W  channel i data at bits [i*W +: W].
REQ-007 SHALL have port in_valid  input  NCH  channel i has a word offered.
REQ-008 SHALL have port in_ready  output  NCH  channel i word is accepted this cycle.
REQ-009 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port sel  input  SW  channel selected in fixed mode.
REQ-011 SHALL have port out_data  output  W  registered selected word.
REQ-012 SHALL have port out_valid  output  1  out_data/out_ch hold a word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts word this cycle.
REQ-014 SHALL have port out_ch  output  SW  source channel index of out_data.

Function
REQ-015 SHALL define transfer on input i as in_valid[i] & in_ready[i] at a rising edge; on output as out_valid & out_ready.
REQ-016 SHALL define slot_free = ~out_valid | out_ready (combinational).
REQ-017 SHALL compute a one-hot grant each cycle; in_ready = grant & {NCH{slot_free}}; at most one in_ready bit high.
REQ-018 SHALL, in fixed mode, grant channel sel only, and only when in_valid[sel]; sel >= NCH grants nothing.
REQ-019 SHALL, in round-robin mode, grant the first valid channel searching from ptr+1 upward, wrapping NCH-1 -> 0.
REQ-020 SHALL update ptr to the granted index only on an input transfer; ptr unchanged otherwise and in fixed mode.
REQ-021 SHALL load out_data <= granted in_data and out_ch <= granted index on an input transfer; latency 1 cycle input-to-output.
REQ-022 SHALL set out_valid to 1 on input transfer, clear it on output transfer with no input transfer, hold it otherwise.
REQ-023 SHALL hold out_data and out_ch stable while out_valid & ~out_ready.
REQ-024 SHALL support simultaneous output and input transfer in one cycle (full throughput, one word per cycle).
REQ-025 SHALL evaluate mode and sel combinationally each cycle; a change takes effect on the same-cycle grant, no word lost or duplicated.
REQ-026 SHALL, with no in_valid bit set, grant nothing and keep in_ready all zero.
REQ-027 SHALL make in_ready independent of in_data; in_ready may depend on in_valid, mode, sel, ptr, out_valid, out_ready.

Reset
REQ-028 SHALL, while rst_n = 0 at a rising edge, set out_valid = 0, out_data = 0, out_ch = 0, ptr = NCH-1 (channel 0 first priority).
REQ-029 SHALL drive in_ready all zero during any cycle where rst_n = 0.
REQ-030 SHALL discard a held output word when reset asserts mid-operation; no transfer counts in that cycle.

Verification
REQ-031 SHALL pass: NCH=4,W=8, mode=1, in_valid=4'b1111, data ch i = 8'h10+i, out_ready=1 constant -> out_ch sequence 0,1,2,3,0 one per cycle, out_data 8'h10,8'h11,8'h12,8'h13,8'h10.
REQ-032 SHALL pass: mode=0, sel=2, in_valid=4'b1111 -> only in_ready[2] ever high; out_ch=2, out_data=8'h12 every cycle.
REQ-033 SHALL pass: mode=1, in_valid=4'b1010, out_ready=0 after first word -> out_valid=1, out_ch=1, out_data held 8'h11, in_ready=0 for 5 cycles; release out_ready -> next out_ch=3.
REQ-034 SHALL pass: mode=1, after grant ch 3, in_valid=4'b0011 -> next grant ch 0 (wrap), then ch 1.
REQ-035 SHALL pass: reset pulsed while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_ch=0; first post-reset round-robin grant with in_valid=4'b1111 is ch 0.
REQ-036 SHALL pass: mode toggled 1->0 with sel=3 mid-stream, scoreboard on every transfer -> no word dropped or duplicated, all post-toggle out_ch=3.

Source files
------------

// File: rtl/chan_mux_rr.sv
// N-channel to 1 registered multiplexer with fixed-select or round-robin arbitration.
// One output word register; full throughput when downstream drains every cycle.
module chan_mux_rr #(
  parameter int NCH = 4,
  parameter int W   = 8,
  parameter int SW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SW-1:0]     out_ch
);

  logic [NCH-1:0][W-1:0] din;
  logic [NCH-1:0]        grant;
  logic [SW-1:0]         gidx;
  logic                  gany;
  logic                  slot_free, in_xfer, out_xfer;

  logic                  vld_q, vld_d;
  logic [W-1:0]          data_q, data_d;
  logic [SW-1:0]         ch_q, ch_d;
  logic [SW-1:0]         ptr_q, ptr_d;

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign din[i] = in_data[i*W +: W];
  end

  // Grant never looks at in_data; RR search starts just past the last winner.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    gidx  = '0;
    gany  = 1'b0;
    if (!mode) begin
      for (int i = 0; i < NCH; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          grant[i] = 1'b1;
          gidx     = SW'(i);
          gany     = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        idx = (int'(ptr_q) + k) % NCH;
        if (!gany && in_valid[idx]) begin
          grant[idx] = 1'b1;
          gidx       = SW'(idx);
          gany       = 1'b1;
        end
      end
    end
  end

  assign slot_free = ~vld_q | out_ready;
  assign in_ready  = rst_n ? (grant & {NCH{slot_free}}) : '0;
  assign in_xfer   = |in_ready;
  assign out_xfer  = vld_q & out_ready;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ch_d   = ch_q;
    ptr_d  = ptr_q;
    if (in_xfer) begin
      vld_d  = 1'b1;
      data_d = din[gidx];
      ch_d   = gidx;
      if (mode) ptr_d = gidx;
    end else if (out_xfer) begin
      vld_d  = 1'b0;
    end
  end

  // Reset parks the pointer on the last channel so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ch_q   <= '0;
      ptr_q  <= SW'(NCH-1);
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ch_q   <= ch_d;
      ptr_q  <= ptr_d;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;
  assign out_ch    = ch_q;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed + randomized bench for chan_mux_rr against a transaction-level model
// (pointer, one-word output slot) plus an in-order word scoreboard.
module tb_chan_mux_rr;
  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int SW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*W-1:0]  in_data = '0;
  logic [NCH-1:0]    in_valid = '0;
  logic [NCH-1:0]    in_ready;
  logic              mode = 1'b0;
  logic [SW-1:0]     sel = '0;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [SW-1:0]     out_ch;

  int tests = 0;
  int fails = 0;

  int              m_ptr  = NCH-1;
  bit              m_v    = 1'b0;
  logic [W-1:0]    m_data = '0;
  int              m_ch   = 0;
  bit              m_ld   = 1'b0;
  logic [SW+W-1:0] sb[$];

  chan_mux_rr #(.NCH(NCH), .W(W), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel that should win this cycle, or -1.
  function automatic int mgrant();
    if (!mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 1; k <= NCH; k++) begin
      int c;
      c = (m_ptr + k) % NCH;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    int             g;
    bit             sf;
    logic [NCH-1:0] er;
    #1;
    g  = mgrant();
    sf = !m_v || out_ready;
    er = (rst_n && g >= 0 && sf) ? NCH'(1 << g) : '0;
    chk("in_ready", in_ready, er);
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_spurious_word", out_valid, 0);
      else chk("sb_word", {out_ch, out_data}, sb.pop_front());
    end
    @(posedge clk);
    m_ld = 1'b0;
    if (!rst_n) begin
      m_v = 1'b0; m_data = '0; m_ch = 0; m_ptr = NCH-1;
      sb.delete();
    end else if (er != 0) begin
      m_v    = 1'b1;
      m_data = in_data[g*W +: W];
      m_ch   = g;
      m_ld   = 1'b1;
      if (mode) m_ptr = g;
      sb.push_back({SW'(g), in_data[g*W +: W]});
    end else if (m_v && out_ready) begin
      m_v = 1'b0;
    end
    #1;
    chk("out_valid", out_valid, m_v);
    chk("out_data", out_data, m_data);
    chk("out_ch", out_ch, m_ch);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < NCH; i++) in_data[i*W +: W] = W'(8'h10 + i);
  endtask

  initial begin
    // Reset with all channels offering: nothing may be accepted.
    in_valid = '1; mode = 1'b1; set_ramp();
    repeat (2) cycle();

    // Round-robin sweep at full throughput.
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_seq_ch", out_ch, k % NCH);
      chk("rr_seq_data", out_data, 8'h10 + (k % NCH));
    end

    // Fixed select on channel 2.
    mode = 1'b0; sel = 2'd2;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("fix_ch", out_ch, 2);
      chk("fix_data", out_data, 8'h12);
    end

    // Nothing offered.
    in_valid = '0;
    repeat (2) cycle();
    chk("idle_valid", out_valid, 0);

    // Backpressure hold, then resume onto next valid channel.
    rst_n = 1'b0; cycle();
    rst_n = 1'b1; mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    cycle();
    chk("bp_first_ch", out_ch, 1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_ch", out_ch, 1);
      chk("bp_hold_data", out_data, 8'h11);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_resume_ch", out_ch, 3);

    // Wrap from channel 3 back to 0.
    in_valid = 4'b0011;
    cycle(); chk("wrap_ch0", out_ch, 0);
    cycle(); chk("wrap_ch1", out_ch, 1);

    // Reset while a word is stalled in the output slot.
    in_valid = '1; out_ready = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", out_data, 0);
    chk("rst_mid_ch", out_ch, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    cycle();
    chk("rst_first_ch", out_ch, 0);

    // Random stream with a round-robin -> fixed(3) toggle midway.
    mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      in_valid = NCH'($urandom); in_data = $urandom; out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    mode = 1'b0; sel = 2'd3;
    for (int k = 0; k < 40; k++) begin
      in_valid = NCH'($urandom); in_data = $urandom; out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (m_ld) chk("toggle_ch", out_ch, 3);
    end

    // Fully random mix including mode/sel changes and occasional reset.
    for (int k = 0; k < 400; k++) begin
      in_valid  = NCH'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      mode      = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 7) == 0) sel = SW'($urandom);
      rst_n     = ($urandom_range(0, 49) != 0);
      cycle();
    end

    rst_n = 1'b1; in_valid = '0; out_ready = 1'b1;
    repeat (2) cycle();
    chk("drain_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
